// File: rtl/class_argmax_stage_if.sv
// Stream bundle for the class argmax stage: score input, bias table writes, result output.
// Pure wiring; no state and no added latency.
// The slave side accepts scores and bias writes; the master side consumes results.
interface class_argmax_stage_if #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
);
    // Score stream from the MAC accumulators
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    // Bias table write port
    logic                  bias_we;
    logic [IDX_WIDTH-1:0]  bias_addr;
    logic [DATA_WIDTH-1:0] bias_data;

    // Per-frame result stream
    logic                  out_valid;
    logic                  out_ready;
    logic [IDX_WIDTH-1:0]  out_class;
    logic [DATA_WIDTH-1:0] out_score;

    // The argmax stage itself
    modport slave (
        input  in_valid,
        input  in_data,
        input  bias_we,
        input  bias_addr,
        input  bias_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_class,
        output out_score
    );

    // The surrounding logic that feeds scores and takes results
    modport master (
        output in_valid,
        output in_data,
        output bias_we,
        output bias_addr,
        output bias_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_class,
        input  out_score
    );
endinterface

// File: rtl/class_argmax_stage.sv
// Adds a per-class bias (saturating) to each neuron score and tracks the running argmax per frame.
// Latency: result valid the cycle after the last score of a frame is accepted.
// Backpressure: in_ready drops while a result is held; the result holds until out_ready.
module class_argmax_stage #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    class_argmax_stage_if.slave bus
);

    // Two-state frame sequencer: gather scores, then present one result
    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_RESULT  = 1'b1;

    localparam logic signed [DATA_WIDTH-1:0] SCORE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] SCORE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_ONE     = IDX_WIDTH'(1);
    localparam logic [IDX_WIDTH:0]   NUM_CLS_EXT = (IDX_WIDTH + 1)'(NUM_CLASSES);

    // Sequencer and frame position
    logic [0:0]                    state_q, state_d;
    logic [IDX_WIDTH-1:0]          idx_q, idx_d;

    // Running maximum within the current frame
    logic signed [DATA_WIDTH-1:0]  best_score_q, best_score_d;
    logic [IDX_WIDTH-1:0]          best_class_q, best_class_d;

    // Registered result
    logic                          out_valid_q, out_valid_d;
    logic [IDX_WIDTH-1:0]          out_class_q, out_class_d;
    logic signed [DATA_WIDTH-1:0]  out_score_q, out_score_d;

    // Bias table, one entry per class
    logic signed [DATA_WIDTH-1:0]  bias_q [NUM_CLASSES];

    // Datapath intermediates
    logic                          in_ready;
    logic                          accept;
    logic                          bias_wr_ok;
    logic signed [DATA_WIDTH-1:0]  in_score;
    logic signed [DATA_WIDTH-1:0]  cur_bias;
    logic signed [DATA_WIDTH:0]    sum_ext;
    logic signed [DATA_WIDTH-1:0]  sat_sum;
    logic                          take_new;
    logic signed [DATA_WIDTH-1:0]  cand_score;
    logic [IDX_WIDTH-1:0]          cand_class;

    // Ready depends only on state, so it never combinationally follows in_valid
    assign in_ready   = (state_q == ST_COLLECT);
    assign accept     = bus.in_valid && in_ready;
    assign in_score   = $signed(bus.in_data);

    // Out-of-range addresses would otherwise hit nonexistent entries; drop them
    assign bias_wr_ok = bus.bias_we && ({1'b0, bus.bias_addr} < NUM_CLS_EXT);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;
    assign bus.out_score = out_score_q;

    // Select the bias for the class currently arriving (registered table, so a same-cycle write is not seen)
    always_comb begin
        cur_bias = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                cur_bias = bias_q[i];
            end
        end
    end

    // Biased sum with one guard bit, clamped to the signed range, then compared against the running best
    always_comb begin
        sum_ext = {in_score[DATA_WIDTH-1], in_score} + {cur_bias[DATA_WIDTH-1], cur_bias};
        if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1]) begin
            // Guard and sign bits disagree: the true sum left the representable range
            sat_sum = sum_ext[DATA_WIDTH] ? SCORE_MIN : SCORE_MAX;
        end else begin
            sat_sum = sum_ext[DATA_WIDTH-1:0];
        end
        // Strict compare keeps the lowest index on ties; class 0 seeds the frame unconditionally
        take_new   = (idx_q == '0) || (sat_sum > best_score_q);
        cand_score = take_new ? sat_sum : best_score_q;
        cand_class = take_new ? idx_q : best_class_q;
    end

    // Frame sequencing: fold in each accepted score, publish after the last class, hold until consumed
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        best_score_d = best_score_q;
        best_class_d = best_class_q;
        out_valid_d  = out_valid_q;
        out_class_d  = out_class_q;
        out_score_d  = out_score_q;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    best_score_d = cand_score;
                    best_class_d = cand_class;
                    if (idx_q == LAST_IDX) begin
                        // Result reflects the final sample as well
                        out_class_d = cand_class;
                        out_score_d = cand_score;
                        out_valid_d = 1'b1;
                        idx_d       = '0;
                        state_d     = ST_RESULT;
                    end else begin
                        idx_d = idx_q + IDX_ONE;
                    end
                end
            end
            ST_RESULT: begin
                if (out_valid_q && bus.out_ready) begin
                    // Result and class index stay visible; only the running max is rearmed
                    out_valid_d  = 1'b0;
                    best_score_d = SCORE_MIN;
                    best_class_d = '0;
                    state_d      = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_COLLECT;
            idx_q        <= '0;
            best_score_q <= SCORE_MIN;
            best_class_q <= '0;
            out_valid_q  <= 1'b0;
            out_class_q  <= '0;
            out_score_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            best_score_q <= best_score_d;
            best_class_q <= best_class_d;
            out_valid_q  <= out_valid_d;
            out_class_q  <= out_class_d;
            out_score_q  <= out_score_d;
        end
    end

    // Bias table: writable in any state, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                bias_q[i] <= '0;
            end
        end else if (bias_wr_ok) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                if (bus.bias_addr == IDX_WIDTH'(i)) begin
                    bias_q[i] <= $signed(bus.bias_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_class_argmax_stage.sv
// Directed bench for class_argmax_stage: table of frames plus hand sequences for
// backpressure, mid-frame reset, ignored bias writes and same-cycle bias write/use.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_class_argmax_stage;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    class_argmax_stage_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) bus ();

    class_argmax_stage #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC),
        .IDX_WIDTH  (IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [NC-1:0][DW-1:0] scores;
        logic [NC-1:0][DW-1:0] bias;
        logic [IW-1:0]         exp_class;
        logic [DW-1:0]         exp_score;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is at a falling edge; returns at the next falling edge
    task automatic write_bias(input logic [IW-1:0] a, input logic [DW-1:0] d);
        bus.bias_we   = 1'b1;
        bus.bias_addr = a;
        bus.bias_data = d;
        @(negedge clk);
        bus.bias_we   = 1'b0;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Streams one frame; returns at the falling edge just after the last accept
    task automatic push_frame(input logic [NC-1:0][DW-1:0] s, input string name);
        for (int i = 0; i < NC; i++) begin
            int n;
            n = 0;
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            while (!bus.in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            check({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
            if (i == NC - 1) check({name, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Expects out_ready=1: result visible now, consumed at the next edge, values held after
    task automatic check_result(input logic [IW-1:0] ec, input logic [DW-1:0] es, input string name);
        check({name, "_valid"},    32'(bus.out_valid), 32'd1);
        check({name, "_class"},    32'(bus.out_class), 32'(ec));
        check({name, "_score"},    32'(bus.out_score), 32'(es));
        check({name, "_rdy_low"},  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        check({name, "_valid_clr"},  32'(bus.out_valid), 32'd0);
        check({name, "_rdy_back"},   32'(bus.in_ready),  32'd1);
        check({name, "_class_hold"}, 32'(bus.out_class), 32'(ec));
        check({name, "_score_hold"}, 32'(bus.out_score), 32'(es));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NC-1:0][DW-1:0] zeros;
        logic [NC-1:0][DW-1:0] s;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.bias_we   = 1'b0;
        bus.bias_addr = '0;
        bus.bias_data = '0;
        bus.out_ready = 1'b1;
        zeros         = '0;

        // Frame table
        for (int k = 0; k < 8; k++) vecs[k] = '0;
        // 10,20,...,100: last class wins
        for (int i = 0; i < NC; i++) vecs[0].scores[i] = 16'(10 * (i + 1));
        vecs[0].exp_class = 4'd9;  vecs[0].exp_score = 16'd100;
        // Tie between classes 3 and 7: lowest index
        for (int i = 0; i < NC; i++) vecs[1].scores[i] = 16'd5;
        vecs[1].scores[3] = 16'd42; vecs[1].scores[7] = 16'd42;
        vecs[1].exp_class = 4'd3;  vecs[1].exp_score = 16'd42;
        // Positive saturation
        vecs[2].scores[2] = 16'h2000; vecs[2].bias[2] = 16'h7000;
        vecs[2].exp_class = 4'd2;  vecs[2].exp_score = 16'h7FFF;
        // Negative saturation everywhere: class 0 holds
        for (int i = 0; i < NC; i++) begin
            vecs[3].scores[i] = 16'h8000; vecs[3].bias[i] = 16'hFFFF;
        end
        vecs[3].exp_class = 4'd0;  vecs[3].exp_score = 16'h8000;
        // Bias alone picks the winner
        vecs[4].bias[4] = 16'd50;
        vecs[4].exp_class = 4'd4;  vecs[4].exp_score = 16'd50;
        // All negative: -100 everywhere, class 6 at -3
        for (int i = 0; i < NC; i++) vecs[5].scores[i] = 16'hFF9C;
        vecs[5].scores[6] = 16'hFFFD;
        vecs[5].exp_class = 4'd6;  vecs[5].exp_score = 16'hFFFD;
        // Biases create a tie at 101 between 8 and 9
        for (int i = 0; i < NC; i++) vecs[6].scores[i] = 16'd100;
        vecs[6].bias[8] = 16'd1; vecs[6].bias[9] = 16'd1;
        vecs[6].exp_class = 4'd8;  vecs[6].exp_score = 16'd101;
        // Class 0: 500-600=-100; others -200; class 9: 0x7FFF+0x8000=-1 wins
        for (int i = 0; i < NC; i++) vecs[7].scores[i] = 16'hFF38;
        vecs[7].scores[0] = 16'd500;   vecs[7].bias[0] = 16'hFDA8;
        vecs[7].scores[9] = 16'h7FFF;  vecs[7].bias[9] = 16'h8000;
        vecs[7].exp_class = 4'd9;  vecs[7].exp_score = 16'hFFFF;

        do_reset();
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_class", 32'(bus.out_class), 32'd0);
        check("rst_out_score", 32'(bus.out_score), 32'd0);

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < NC; j++) write_bias(IW'(j), vecs[k].bias[j]);
            push_frame(vecs[k].scores, $sformatf("vec%0d", k));
            check_result(vecs[k].exp_class, vecs[k].exp_score, $sformatf("vec%0d", k));
        end

        // Backpressure: result held 5 cycles while upstream keeps offering a huge score
        for (int j = 0; j < NC; j++) write_bias(IW'(j), 16'd0);
        bus.out_ready = 1'b0;
        push_frame(vecs[0].scores, "bp");
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h7000;
            check($sformatf("bp_hold%0d_valid", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_hold%0d_class", c), 32'(bus.out_class), 32'd9);
            check($sformatf("bp_hold%0d_score", c), 32'(bus.out_score), 32'd100);
            check($sformatf("bp_hold%0d_rdy",   c), 32'(bus.in_ready),  32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        bus.in_data   = vecs[1].scores[0];
        check("bp_release_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        check("bp_after_valid", 32'(bus.out_valid), 32'd0);
        check("bp_after_rdy",   32'(bus.in_ready),  32'd1);
        push_frame(vecs[1].scores, "bp_next");
        check_result(4'd3, 16'd42, "bp_next");

        // Reset after 4 accepted scores, with a bias that reset must clear
        write_bias(4'd1, 16'd1000);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'h6000;
            @(negedge clk);
        end
        do_reset();
        check("mid_rst_rdy",   32'(bus.in_ready),  32'd1);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_class", 32'(bus.out_class), 32'd0);
        s = '0;
        s[7] = 16'd3;
        push_frame(s, "mid_rst");
        check_result(4'd7, 16'd3, "mid_rst");

        // Out-of-range bias address must not disturb the table
        write_bias(4'd4, 16'd50);
        write_bias(4'd12, 16'h7FFF);
        write_bias(4'd10, 16'h7FFF);
        push_frame(zeros, "addr_oob");
        check_result(4'd4, 16'd50, "addr_oob");

        // Bias write to the class being summed in the same cycle: old value used
        write_bias(4'd4, 16'd0);
        for (int i = 0; i < NC; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'd0;
            bus.bias_we   = (i == 3);
            bus.bias_addr = 4'd3;
            bus.bias_data = 16'd1000;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.bias_we  = 1'b0;
        check_result(4'd0, 16'd0, "wr_same");
        push_frame(zeros, "wr_after");
        check_result(4'd3, 16'd1000, "wr_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
